grad_trap_sequencer: RTL and testbench

Timed valve sequencer for an N-channel gradient cell-trap array: a gradient source feeds a binary-control MUX that routes it into N long cell traps, and a flush tree reaches all traps from a single port. On `start` the block routes the gradient to each enabled trap in turn, holds a culture period with every valve closed, then flushes. It drives the two inlet valves, the flush valve and the complementary pair of MUX control lines per select bit. It sits between the host command register and the pneumatic valve drivers. It generalises the fixed 4-trap device to `N_CH` channels, adds programmable timing, a channel mask and abort.

---
 rtl/grad_trap_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_grad_trap_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_trap_sequencer.sv
// Timed valve sequencer for an N-channel gradient cell-trap array.
// Routes the gradient into each enabled trap in turn, cultures with every valve closed, then flushes.
module grad_trap_sequencer #(
    parameter int N_CH       = 4,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [CNT_W-1:0] load_cycles,
    input  logic [CNT_W-1:0] culture_cycles,
    input  logic [CNT_W-1:0] flush_cycles,
    output logic             inlet_a,
    output logic             inlet_b,
    output logic             flush_en,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic [SEL_W-1:0] cur_ch,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_CULTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [SEL_W-1:0] nxt_ch;
    logic             nxt_aborted;
    logic [SEL_W:0]   hit;

    logic [N_CH-1:0]  mask_q;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] culture_q;
    logic [CNT_W-1:0] flush_q;

    // A programmed duration of zero still occupies one cycle.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Lowest set bit of m at or above position lo; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] first_set_from(input logic [N_CH-1:0] m, input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            mask_q    <= ch_mask;
            load_q    <= at_least_one(load_cycles);
            culture_q <= at_least_one(culture_cycles);
            flush_q   <= at_least_one(flush_cycles);
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_ch      = cur_ch;
        nxt_aborted = aborted;
        hit         = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_aborted = 1'b0;
                    hit = first_set_from(ch_mask, 0);
                    if (hit[SEL_W]) begin
                        nxt_state = S_SETTLE;
                        nxt_ch    = hit[SEL_W-1:0];
                        nxt_cnt   = CNT_W'(SETTLE_CYC);
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    nxt_state = S_LOAD;
                    nxt_cnt   = load_q;
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (cnt == CNT_W'(1)) begin
                    hit = first_set_from(mask_q, int'(cur_ch) + 1);
                    if (hit[SEL_W]) begin
                        nxt_state = S_SETTLE;
                        nxt_ch    = hit[SEL_W-1:0];
                        nxt_cnt   = CNT_W'(SETTLE_CYC);
                    end else begin
                        nxt_state = S_CULTURE;
                        nxt_cnt   = culture_q;
                    end
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_CULTURE: begin
                if (cnt == CNT_W'(1)) begin
                    nxt_state = S_FLUSH;
                    nxt_cnt   = flush_q;
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt == CNT_W'(1)) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        // Abort overrides any natural phase transition before the flush.
        if (abort && (state inside {S_SETTLE, S_LOAD, S_CULTURE})) begin
            nxt_state   = S_FLUSH;
            nxt_cnt     = flush_q;
            nxt_aborted = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_ch   <= '0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            inlet_a  <= 1'b0;
            inlet_b  <= 1'b0;
            flush_en <= 1'b0;
            sel_a    <= '1;
            sel_b    <= '1;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            cur_ch   <= nxt_ch;
            aborted  <= nxt_aborted;
            busy     <= nxt_state inside {S_SETTLE, S_LOAD, S_CULTURE, S_FLUSH};
            done     <= (nxt_state == S_DONE);
            inlet_a  <= (nxt_state == S_LOAD);
            inlet_b  <= (nxt_state == S_LOAD);
            flush_en <= (nxt_state == S_FLUSH);
            case (nxt_state)
                S_SETTLE, S_LOAD: begin
                    sel_a <= nxt_ch;
                    sel_b <= ~nxt_ch;
                end
                S_FLUSH: begin
                    sel_a <= '0;
                    sel_b <= '0;
                end
                default: begin
                    sel_a <= '1;
                    sel_b <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grad_trap_sequencer.sv
// Bench for grad_trap_sequencer: directed vector table plus randomized runs against a
// phase-list reference model that expands each sequence into its expected per-cycle outputs.
module tb_grad_trap_sequencer;

    localparam int N_CH       = 4;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 16;
    localparam int SETTLE_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [N_CH-1:0]  ch_mask;
    logic [CNT_W-1:0] load_cycles;
    logic [CNT_W-1:0] culture_cycles;
    logic [CNT_W-1:0] flush_cycles;
    logic             inlet_a;
    logic             inlet_b;
    logic             flush_en;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] cur_ch;
    logic             busy;
    logic             done;
    logic             aborted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grad_trap_sequencer #(
        .N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
        .load_cycles(load_cycles), .culture_cycles(culture_cycles), .flush_cycles(flush_cycles),
        .inlet_a(inlet_a), .inlet_b(inlet_b), .flush_en(flush_en),
        .sel_a(sel_a), .sel_b(sel_b), .cur_ch(cur_ch),
        .busy(busy), .done(done), .aborted(aborted)
    );

    typedef struct {
        logic [SEL_W-1:0] sa;
        logic [SEL_W-1:0] sb;
        logic             ia;
        logic             ib;
        logic             fl;
        logic             bz;
        logic             dn;
        logic             ab;
        logic [SEL_W-1:0] ch;
        bit               chk_ch;
    } cyc_t;

    // ab: cycle index (after start) during which abort is held; rs: index of a stray start pulse.
    typedef struct {
        logic [N_CH-1:0] mask;
        int              l;
        int              c;
        int              f;
        int              ab;
        int              rs;
        int              exp_busy;
        bit              exp_abt;
    } vec_t;

    cyc_t trace[$];
    bit   final_abt;
    vec_t tbl[$];

    function automatic int at1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // kind: 0 idle, 1 settle, 2 load, 3 culture, 4 flush, 5 done
    function automatic cyc_t mk(input int kind, input int ch, input bit abt);
        cyc_t e;
        logic [SEL_W-1:0] c;
        c = SEL_W'(ch);
        e.sa = '1; e.sb = '1;
        e.ia = 1'b0; e.ib = 1'b0; e.fl = 1'b0;
        e.bz = (kind >= 1 && kind <= 4);
        e.dn = (kind == 5);
        e.ab = abt;
        e.ch = c;
        e.chk_ch = (kind == 1 || kind == 2);
        if (kind == 1 || kind == 2) begin e.sa = c; e.sb = ~c; end
        if (kind == 2) begin e.ia = 1'b1; e.ib = 1'b1; end
        if (kind == 4) begin e.sa = '0; e.sb = '0; e.fl = 1'b1; end
        return e;
    endfunction

    task automatic build(input vec_t v);
        bit cut;
        cut = 1'b0;
        trace.delete();
        for (int c = 0; c < N_CH; c++) begin
            if (v.mask[c]) begin
                repeat (SETTLE_CYC) trace.push_back(mk(1, c, 1'b0));
                repeat (at1(v.l)) trace.push_back(mk(2, c, 1'b0));
            end
        end
        if (v.mask != '0) begin
            repeat (at1(v.c)) trace.push_back(mk(3, 0, 1'b0));
            repeat (at1(v.f)) trace.push_back(mk(4, 0, 1'b0));
        end
        if (v.ab >= 0 && v.ab < int'(trace.size())) begin
            if (trace[v.ab].fl == 1'b0) begin
                while (int'(trace.size()) > v.ab + 1) void'(trace.pop_back());
                repeat (at1(v.f)) trace.push_back(mk(4, 0, 1'b1));
                cut = 1'b1;
            end
        end
        trace.push_back(mk(5, 0, cut));
        final_abt = cut;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cyc(input string tag, input int i, input cyc_t e);
        logic [9:0] got;
        logic [9:0] want;
        got  = {sel_a, sel_b, inlet_a, inlet_b, flush_en, busy, done, aborted};
        want = {e.sa, e.sb, e.ia, e.ib, e.fl, e.bz, e.dn, e.ab};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc%0d {sel_a,sel_b,ia,ib,fl,busy,done,abt} got %b want %b", tag, i, got, want);
        end
        if (e.chk_ch) begin
            checks++;
            if (cur_ch !== e.ch) begin
                errors++;
                $display("FAIL %s cyc%0d cur_ch got %0d want %0d", tag, i, cur_ch, e.ch);
            end
        end
    endtask

    task automatic run(input string tag, input vec_t v, input bit hand);
        int nb;
        nb = 0;
        build(v);
        ch_mask        = v.mask;
        load_cycles    = CNT_W'(v.l);
        culture_cycles = CNT_W'(v.c);
        flush_cycles   = CNT_W'(v.f);
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(trace.size()); i++) begin
            ch_mask        = N_CH'($urandom);
            load_cycles    = CNT_W'($urandom);
            culture_cycles = CNT_W'($urandom);
            flush_cycles   = CNT_W'($urandom);
            check_cyc(tag, i, trace[i]);
            if (busy) nb++;
            abort = (i == v.ab);
            start = (i == v.rs);
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        check_cyc(tag, int'(trace.size()), mk(0, 0, final_abt));
        if (hand) begin
            checks++;
            if (nb != v.exp_busy) begin
                errors++;
                $display("FAIL %s busy_len got %0d want %0d", tag, nb, v.exp_busy);
            end
            checks++;
            if (aborted !== v.exp_abt) begin
                errors++;
                $display("FAIL %s aborted_flag got %b want %b", tag, aborted, v.exp_abt);
            end
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ch_mask = '0; load_cycles = '0; culture_cycles = '0; flush_cycles = '0;

        //            mask     l  c  f  ab  rs  busy abt
        tbl.push_back('{4'b0001, 3, 4, 2, -1, -1, 11, 1'b0}); // single channel
        tbl.push_back('{4'b1010, 2, 3, 2, -1, -1, 13, 1'b0}); // sparse mask
        tbl.push_back('{4'b0001, 0, 0, 0, -1, -1,  5, 1'b0}); // zero durations
        tbl.push_back('{4'b0001, 5, 4, 3,  3, -1,  7, 1'b1}); // abort in 2nd LOAD cycle
        tbl.push_back('{4'b0000, 3, 3, 3, -1, -1,  0, 1'b0}); // empty mask, clears aborted
        tbl.push_back('{4'b0011, 2, 2, 2, -1,  5, 12, 1'b0}); // start while busy
        tbl.push_back('{4'b1111, 1, 1, 1, -1, -1, 14, 1'b0}); // all channels
        tbl.push_back('{4'b0100, 2, 5, 2,  5, -1,  8, 1'b1}); // abort in CULTURE
        tbl.push_back('{4'b1000, 3, 3, 0,  0, -1,  2, 1'b1}); // abort in first SETTLE cycle
        tbl.push_back('{4'b0001, 1, 1, 4,  5, -1,  8, 1'b0}); // abort in FLUSH ignored

        tick();
        tick();
        check_cyc("reset", 0, mk(0, 0, 1'b0));
        checks++;
        if (cur_ch !== '0) begin
            errors++;
            $display("FAIL reset cur_ch got %0d want 0", cur_ch);
        end
        rst = 1'b0;
        tick();

        for (int k = 0; k < tbl.size(); k++) begin
            run($sformatf("vec%0d", k), tbl[k], 1'b1);
            tick();
        end

        // Reset during FLUSH: valves close and the run ends without a done pulse.
        v = '{4'b0001, 1, 1, 5, -1, -1, 0, 1'b0};
        build(v);
        ch_mask = v.mask; load_cycles = 16'd1; culture_cycles = 16'd1; flush_cycles = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_cyc("rst_flush", i, trace[i]);
            if (i < 5) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cyc("rst_flush_after", 0, mk(0, 0, 1'b0));
        checks++;
        if (cur_ch !== '0) begin
            errors++;
            $display("FAIL rst_flush cur_ch got %0d want 0", cur_ch);
        end
        tick();
        check_cyc("rst_flush_after", 1, mk(0, 0, 1'b0));
        tick();

        for (int r = 0; r < 30; r++) begin
            v.mask     = N_CH'($urandom_range(0, 15));
            v.l        = int'($urandom_range(0, 4));
            v.c        = int'($urandom_range(0, 4));
            v.f        = int'($urandom_range(0, 4));
            v.ab       = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1;
            v.rs       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            v.exp_busy = 0;
            v.exp_abt  = 1'b0;
            run($sformatf("rand%0d", r), v, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
